// File: rtl/find_table_mc.sv
`default_nettype none
// ============================================================================
//  Module      : find_table_mc
//  Description : Multi-class free-descriptor table. Holds one "row full"
//                vector per size class plus a shared in-flight reservation
//                mask. Answers alloc requests with the lowest free,
//                unreserved row of the requested class. Fixed 2-cycle
//                latency, valid/ready request side, explicit miss result,
//                registered per-class full status.
//  Revision    : 1.0 - initial release
// ============================================================================
module find_table_mc #(
    parameter int NUM_CLASSES   = 4,
    parameter int CLASS_WIDTH   = 2,
    parameter int ROWS          = 64,
    parameter int ROW_IDX_WIDTH = 6,
    parameter int ID_WIDTH      = 8,
    parameter int MAX_PENDING   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // allocation request
    input  logic                     alloc_valid_in,
    output logic                     alloc_ready_out,
    input  logic [ID_WIDTH-1:0]      alloc_id_in,
    input  logic [CLASS_WIDTH-1:0]   alloc_class_in,
    // allocation result
    output logic                     res_valid_out,
    output logic                     res_hit_out,
    output logic [ID_WIDTH-1:0]      res_id_out,
    output logic [CLASS_WIDTH-1:0]   res_class_out,
    output logic [ROW_IDX_WIDTH-1:0] res_row_out,
    // row update from the AT tree
    input  logic                     upd_valid_in,
    input  logic [ROW_IDX_WIDTH-1:0] upd_idx_in,
    input  logic [NUM_CLASSES-1:0]   upd_bits_in,
    // status
    output logic [NUM_CLASSES-1:0]   class_full_out,
    output logic [ROW_IDX_WIDTH:0]   pending_cnt_out
);

    localparam int                   CNT_WIDTH  = ROW_IDX_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = CNT_WIDTH'(ROWS);
    localparam logic [CNT_WIDTH:0]   PEND_LIMIT = (CNT_WIDTH + 1)'(MAX_PENDING);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ROWS-1:0]          table_q [NUM_CLASSES];
    logic [ROWS-1:0]          mask_q;
    logic [CNT_WIDTH-1:0]     pend_cnt;

    logic                     s1_valid;
    logic [ID_WIDTH-1:0]      s1_id;
    logic [CLASS_WIDTH-1:0]   s1_class;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [CNT_WIDTH:0]       inflight;
    logic                     accept;
    logic                     class_ok;
    logic [ROWS-1:0]          masked;
    logic                     found;
    logic [ROW_IDX_WIDTH-1:0] pick;
    logic                     s1_hit;
    logic                     upd_clear;
    logic [ROWS-1:0]          mask_next;
    logic [CNT_WIDTH-1:0]     cnt_next;

    // The request in stage 1 counts against the limit: it may still
    // reserve a row at the end of this cycle, so the pending count can
    // reach but never exceed MAX_PENDING. Ready never looks at valid.
    assign inflight        = {1'b0, pend_cnt} + {{CNT_WIDTH{1'b0}}, s1_valid};
    assign alloc_ready_out = rst_n & (inflight < PEND_LIMIT);
    assign accept          = alloc_valid_in & alloc_ready_out;
    assign pending_cnt_out = pend_cnt;

    // Stage-1 search: lowest zero bit of (class row-full vector | reservations).
    // An out-of-range class sees an all-ones vector and therefore misses.
    always_comb begin
        class_ok = (int'(s1_class) < NUM_CLASSES);
        masked   = '1;
        if (class_ok) begin
            masked = table_q[s1_class] | mask_q;
        end
        found = 1'b0;
        pick  = '0;
        // Scan downward so the last assignment made is the lowest free row.
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!masked[i]) begin
                found = 1'b1;
                pick  = ROW_IDX_WIDTH'(i);
            end
        end
        s1_hit = s1_valid & found;
    end

    // Next reservation mask and pending count from this cycle's hit and update.
    always_comb begin
        upd_clear = upd_valid_in & mask_q[upd_idx_in];
        mask_next = mask_q;
        if (upd_clear) begin
            mask_next[upd_idx_in] = 1'b0;
        end
        // Applied after the clear so that a reservation of the same row wins.
        if (s1_hit) begin
            mask_next[pick] = 1'b1;
        end

        cnt_next = pend_cnt;
        if (s1_hit && !upd_clear) begin
            if (pend_cnt != CNT_MAX) begin
                cnt_next = pend_cnt + CNT_WIDTH'(1);
            end
        end else if (!s1_hit && upd_clear) begin
            if (pend_cnt != '0) begin
                cnt_next = pend_cnt - CNT_WIDTH'(1);
            end
        end
    end

    // Reservation mask and pending counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q   <= '0;
            pend_cnt <= '0;
        end else begin
            mask_q   <= mask_next;
            pend_cnt <= cnt_next;
        end
    end

    // Row-full tables: an update rewrites one row of every class at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                table_q[c] <= '0;
            end
        end else if (upd_valid_in) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                table_q[c][upd_idx_in] <= upd_bits_in[c];
            end
        end
    end

    // Per-class full status, registered from the current table and mask
    // (one cycle behind the state it describes).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            class_full_out <= '0;
        end else begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                class_full_out[c] <= &(table_q[c] | mask_q);
            end
        end
    end

    // Stage 1: capture the accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_class <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_id    <= alloc_id_in;
                s1_class <= alloc_class_in;
            end
        end
    end

    // Stage 2: registered result, strobed for one cycle per request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_out <= 1'b0;
            res_hit_out   <= 1'b0;
            res_id_out    <= '0;
            res_class_out <= '0;
            res_row_out   <= '0;
        end else begin
            res_valid_out <= s1_valid;
            if (s1_valid) begin
                res_hit_out   <= s1_hit;
                res_id_out    <= s1_id;
                res_class_out <= s1_class;
                res_row_out   <= s1_hit ? pick : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_find_table_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_find_table_mc
//  Description : Self-checking bench for find_table_mc. An array-based model
//                of the table tracks expected outputs every cycle; directed
//                sequences add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_find_table_mc;

    localparam int NC    = 4;
    localparam int CW    = 2;
    localparam int ROWS  = 64;
    localparam int RW    = 6;
    localparam int IDW   = 8;
    localparam int MAXP  = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           alloc_valid_in = 1'b0;
    logic           alloc_ready_out;
    logic [IDW-1:0] alloc_id_in = '0;
    logic [CW-1:0]  alloc_class_in = '0;
    logic           res_valid_out;
    logic           res_hit_out;
    logic [IDW-1:0] res_id_out;
    logic [CW-1:0]  res_class_out;
    logic [RW-1:0]  res_row_out;
    logic           upd_valid_in = 1'b0;
    logic [RW-1:0]  upd_idx_in = '0;
    logic [NC-1:0]  upd_bits_in = '0;
    logic [NC-1:0]  class_full_out;
    logic [RW:0]    pending_cnt_out;

    find_table_mc #(
        .NUM_CLASSES(NC), .CLASS_WIDTH(CW), .ROWS(ROWS),
        .ROW_IDX_WIDTH(RW), .ID_WIDTH(IDW), .MAX_PENDING(MAXP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid_in(alloc_valid_in), .alloc_ready_out(alloc_ready_out),
        .alloc_id_in(alloc_id_in), .alloc_class_in(alloc_class_in),
        .res_valid_out(res_valid_out), .res_hit_out(res_hit_out),
        .res_id_out(res_id_out), .res_class_out(res_class_out),
        .res_row_out(res_row_out),
        .upd_valid_in(upd_valid_in), .upd_idx_in(upd_idx_in),
        .upd_bits_in(upd_bits_in),
        .class_full_out(class_full_out), .pending_cnt_out(pending_cnt_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: plain arrays of bits and an integer counter.
    // ------------------------------------------------------------------
    bit          m_tbl [NC][ROWS];
    bit          m_mask [ROWS];
    int          m_cnt;
    bit          m_s1v;
    int          m_s1id, m_s1cl;
    bit          m_rv, m_rh;
    int          m_rid, m_rcl, m_rrow;
    logic [NC-1:0] m_full;

    task automatic model_reset();
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < ROWS; r++) m_tbl[c][r] = 1'b0;
        for (int r = 0; r < ROWS; r++) m_mask[r] = 1'b0;
        m_cnt = 0; m_s1v = 0; m_s1id = 0; m_s1cl = 0;
        m_rv = 0; m_rh = 0; m_rid = 0; m_rcl = 0; m_rrow = 0;
        m_full = '0;
    endtask

    function automatic bit model_ready();
        return rst_n && ((m_cnt + int'(m_s1v)) < MAXP);
    endfunction

    // Advance the model one clock using the inputs presented at this edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            bit acc, hit, clr, full;
            int row, idx;
            logic [NC-1:0] nfull;
            acc = alloc_valid_in && model_ready();
            for (int c = 0; c < NC; c++) begin
                full = 1;
                for (int r = 0; r < ROWS; r++)
                    if (!(m_tbl[c][r] || m_mask[r])) full = 0;
                nfull[c] = full;
            end
            hit = 0; row = 0;
            if (m_s1v && m_s1cl < NC) begin
                for (int r = 0; r < ROWS; r++)
                    if (!hit && !(m_tbl[m_s1cl][r] || m_mask[r])) begin
                        hit = 1; row = r;
                    end
            end
            idx = int'(upd_idx_in);
            clr = upd_valid_in && m_mask[idx];
            if (upd_valid_in)
                for (int c = 0; c < NC; c++) m_tbl[c][idx] = upd_bits_in[c];
            if (clr) m_mask[idx] = 1'b0;
            if (hit) m_mask[row] = 1'b1;
            m_cnt = m_cnt + int'(hit) - int'(clr);
            if (m_cnt > ROWS) m_cnt = ROWS;
            if (m_cnt < 0) m_cnt = 0;
            m_rv = m_s1v;
            if (m_s1v) begin
                m_rh = hit; m_rid = m_s1id; m_rcl = m_s1cl; m_rrow = hit ? row : 0;
            end
            m_s1v = acc;
            if (acc) begin
                m_s1id = int'(alloc_id_in); m_s1cl = int'(alloc_class_in);
            end
            m_full = nfull;
        end
    end

    // ------------------------------------------------------------------
    // Compare process and result log
    // ------------------------------------------------------------------
    typedef struct { int id; int hit; int row; int cl; } res_t;
    res_t got [$];

    always @(negedge clk) begin
        check("ready", int'(alloc_ready_out), int'(model_ready()));
        check("pending_cnt", int'(pending_cnt_out), m_cnt);
        check("class_full", int'(class_full_out), int'(m_full));
        check("res_valid", int'(res_valid_out), int'(m_rv));
        if (m_rv) begin
            check("res_hit", int'(res_hit_out), int'(m_rh));
            check("res_id", int'(res_id_out), m_rid);
            check("res_class", int'(res_class_out), m_rcl);
            check("res_row", int'(res_row_out), m_rrow);
        end
        if (res_valid_out) begin
            res_t e;
            e.id = int'(res_id_out); e.hit = int'(res_hit_out);
            e.row = int'(res_row_out); e.cl = int'(res_class_out);
            got.push_back(e);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all run in the phase just after a rising edge)
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input int id, input int cl);
        bit acc = 0;
        int k = 0;
        alloc_valid_in = 1'b1;
        alloc_id_in    = IDW'(id);
        alloc_class_in = CW'(cl);
        while (!acc && k < 20) begin
            acc = alloc_ready_out;
            @(posedge clk); #1;
            k++;
        end
        alloc_valid_in = 1'b0;
        if (!acc) check("send_accept_timeout", 0, 1);
    endtask

    task automatic update(input int idx, input logic [NC-1:0] bits);
        upd_valid_in = 1'b1;
        upd_idx_in   = RW'(idx);
        upd_bits_in  = bits;
        @(posedge clk); #1;
        upd_valid_in = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int k = 0;
        while (got.size() < n && k < 20) begin @(posedge clk); #1; k++; end
        check("result_count", got.size(), n);
    endtask

    task automatic expect_res(input int i, input int id, input int hit, input int row);
        if (i < got.size()) begin
            check("lit_id", got[i].id, id);
            check("lit_hit", got[i].hit, hit);
            check("lit_row", got[i].row, row);
        end else begin
            check("lit_result_present", 0, 1);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int accepted;
        model_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("lit_ready_in_reset", int'(alloc_ready_out), 0);
        check("lit_res_valid_in_reset", int'(res_valid_out), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("lit_ready_after_reset", int'(alloc_ready_out), 1);
        check("lit_pending_after_reset", int'(pending_cnt_out), 0);
        idle(1);

        // Three back-to-back class 1 requests -> rows 0,1,2
        got.delete();
        send(1, 1); send(2, 1); send(3, 1);
        wait_results(3);
        expect_res(0, 1, 1, 0);
        expect_res(1, 2, 1, 1);
        expect_res(2, 3, 1, 2);
        check("lit_pending_3", int'(pending_cnt_out), 3);

        // Update row 1: releases reservation, marks class 1 row 1 full
        update(1, 4'b0010);
        check("lit_pending_2", int'(pending_cnt_out), 2);
        got.delete();
        send(4, 1);
        wait_results(1);
        expect_res(0, 4, 1, 3);
        got.delete();
        send(5, 0);
        wait_results(1);
        expect_res(0, 5, 1, 1);

        // Pending limit: 10 held requests, only 8 accepted
        pulse_reset();
        idle(1);
        accepted = 0;
        alloc_class_in = '0;
        alloc_valid_in = 1'b1;
        for (int k = 0; k < 14; k++) begin
            alloc_id_in = IDW'(10 + accepted);
            if (alloc_ready_out && accepted < 10) accepted++;
            @(posedge clk); #1;
            if (accepted >= 10) alloc_valid_in = 1'b0;
        end
        alloc_valid_in = 1'b0;
        check("lit_accepted", accepted, 8);
        check("lit_ready_low_at_limit", int'(alloc_ready_out), 0);
        check("lit_pending_8", int'(pending_cnt_out), 8);
        update(0, 4'b0000);
        check("lit_ready_after_free", int'(alloc_ready_out), 1);
        check("lit_pending_7", int'(pending_cnt_out), 7);

        // Fill class 3 completely; class 3 request misses
        for (int r = 0; r < ROWS; r++) update(r, 4'b1000);
        idle(2);
        check("lit_class_full", int'(class_full_out), 8);
        check("lit_pending_0", int'(pending_cnt_out), 0);
        got.delete();
        send(77, 3);
        wait_results(1);
        expect_res(0, 77, 0, 0);
        check("lit_pending_after_miss", int'(pending_cnt_out), 0);

        // Same-edge reserve of row 5 and update of the unreserved row 5
        got.delete();
        for (int i = 0; i < 6; i++) send(20 + i, 0);
        update(5, 4'b0000);
        check("lit_pending_same_row", int'(pending_cnt_out), 6);
        wait_results(6);
        expect_res(5, 25, 1, 5);
        got.delete();
        send(26, 0);
        wait_results(1);
        expect_res(0, 26, 1, 6);
        check("lit_pending_7b", int'(pending_cnt_out), 7);
        update(5, 4'b0000);
        check("lit_pending_6b", int'(pending_cnt_out), 6);

        // Reset with two requests in flight
        idle(2);
        got.delete();
        send(30, 0); send(31, 0);
        rst_n = 1'b0;
        idle(3);
        check("lit_outputs_in_reset", int'({res_valid_out, res_hit_out, res_id_out,
              res_class_out, res_row_out, class_full_out, pending_cnt_out}), 0);
        rst_n = 1'b1;
        idle(3);
        check("lit_no_result_after_reset", got.size(), 0);
        check("lit_class_full_cleared", int'(class_full_out), 0);
        send(40, 1);
        wait_results(1);
        expect_res(0, 40, 1, 0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/find_table_mc.md
Name: find_table_mc

Overview:
- Parametrised multi-class free-descriptor table; successor to the fixed 4-class/64-row find table.
- Sits between the dispatcher and the AT tree.
- Holds one ROWS-bit "row full" vector per size class plus a shared in-flight reservation mask.
- Answers alloc requests with the lowest free, unreserved row for the requested class, with a fixed 2-cycle latency and a valid/ready request handshake.
- Adds an explicit miss response and per-class full status, replacing the single blocked flag. Tables are flops, not RAM.

Parameters:
- NUM_CLASSES, 4, number of size classes (class 0 = smallest).
- CLASS_WIDTH, 2, width of class field; 2**CLASS_WIDTH >= NUM_CLASSES.
- ROWS, 64, rows per class vector (power of two, 8..256).
- ROW_IDX_WIDTH, 6, log2(ROWS).
- ID_WIDTH, 8, request id width.
- MAX_PENDING, 8, max reserved rows awaiting update (1..ROWS).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alloc_valid_in  in  1  request valid
- alloc_ready_out  out  1  request accepted when valid&&ready
- alloc_id_in  in  ID_WIDTH  request id
- alloc_class_in  in  CLASS_WIDTH  size class
- res_valid_out  out  1  result strobe, one cycle
- res_hit_out  out  1  1 = row found and reserved, 0 = miss
- res_id_out  out  ID_WIDTH  echoed id
- res_class_out  out  CLASS_WIDTH  echoed class
- res_row_out  out  ROW_IDX_WIDTH  row index (0 on miss)
- upd_valid_in  in  1  update from AT tree
- upd_idx_in  in  ROW_IDX_WIDTH  row to update
- upd_bits_in  in  NUM_CLASSES  new full bit per class for that row
- class_full_out  out  NUM_CLASSES  registered: (table[c] | mask) all ones
- pending_cnt_out  out  ROW_IDX_WIDTH+1  rows currently reserved

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all table bits 0 (all free); mask 0; pipeline valids 0; all outputs 0, except alloc_ready_out = 1 once rst_n is high.
- Reset mid-operation discards in-flight requests; no result is emitted for them.
- Accept (cycle T): the request is captured into stage 1 when alloc_valid_in && alloc_ready_out.
- alloc_ready_out = (pending_cnt + s1_valid) < MAX_PENDING. This is combinational from registers only, never from alloc_valid_in.
- Class out of range (>= NUM_CLASSES): the request is accepted and answered with a miss; mask and counter are unchanged.
- Stage 1 (cycle T+1):
  - masked = table[class] | mask, using register values after the T edge.
  - Pick the lowest-index zero bit.
  - Hit: set mask[row] at the end of T+1 and increment the counter.
  - Miss: all bits of masked are 1; no state change.
- Stage 2 (cycle T+2): registered result; res_valid_out high for exactly one cycle. Latency is 2 cycles from accept.
- Back-to-back: a request accepted at T+1 searches at T+2 and sees the mask bit set at the end of T+1. Consecutive hits never return the same row. Sustained throughput is one request per cycle while ready.
- Update (cycle U), applied at the end of U:
  - table[c][upd_idx] = upd_bits[c] for all c.
  - If mask[upd_idx] = 1: clear it and decrement the counter.
  - If mask[upd_idx] = 0: the mask and counter are unchanged.
- Update effects are visible to stage-1 searches in U+1 onward.
- Same-edge set and clear:
  - Different rows: both apply.
  - Same row (update to an unreserved row while stage 1 reserves it): the set wins, and the counter takes the net of both events.
- Counter:
  - Saturates at ROWS and never underflows.
  - May reach MAX_PENDING; it is never exceeded by accepted requests because the in-flight count is included in ready.
- class_full_out is registered from post-edge table/mask, so it lags state by 1 cycle.

Test Plan:
- Reset, then class 1 requests ids 1,2,3 back-to-back -> res_valid at T+2..T+4, hit=1, rows 0,1,2, pending_cnt 3. No duplicate row.
- Update idx=1 with upd_bits=4'b0010 -> mask bit 1 clears, pending_cnt 2, table[1][1]=1. The next class 1 request returns row 3; a class 0 request returns row 1.
- MAX_PENDING=8, 10 requests held valid with no updates -> exactly 8 accepted, alloc_ready_out low after the 8th accept. One update reserves a slot; ready returns the following cycle.
- Set table[3] to all ones via updates for rows 0..63 -> class_full_out[3]=1. A class 3 request returns hit=0, row=0, id echoed, mask unchanged.
- Update idx=5 (unreserved) in the same cycle stage 1 reserves row 5 -> mask[5]=1 remains and pending_cnt increments by 1.
- Assert rst_n low while 2 requests are in flight -> no res_valid afterwards, all outputs 0, tables cleared, the first request after reset gets row 0.
